// File: rtl/wiper_pkg.sv
// Shared types and helpers for the wiper sweep sequencer.
// Speed and state encodings plus the half-sweep length function.
package wiper_pkg;

  typedef enum logic [1:0] {
    SPD_OFF  = 2'd0,
    SPD_SLOW = 2'd1,
    SPD_FAST = 2'd2
  } speed_t;

  typedef enum logic [1:0] {
    PARK  = 2'd0,
    OUT   = 2'd1,
    BACK  = 2'd2,
    DWELL = 2'd3
  } wiper_state_t;

  function automatic int half_len(
    speed_t s,
    int     sweep,
    int     div
  );
    return (s == SPD_FAST) ? sweep : sweep * div;
  endfunction

  function automatic speed_t eff_speed(
    logic [1:0] r
  );
    speed_t s;
    unique case (r)
      2'd1:    s = SPD_SLOW;
      2'd2:    s = SPD_FAST;
      default: s = SPD_OFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/wiper_sweep_sequencer_if.sv
// Command/status bundle between rain classifier and wiper sequencer.
// master drives requests, slave is the sequencer.
interface wiper_sweep_sequencer_if;

  logic [1:0] speed_req;
  logic       wash_req;
  logic       motor_en;
  logic       motor_dir;
  logic       wash_pump;
  logic [1:0] st;
  logic [7:0] sweep_cnt;

  modport master (
    output speed_req,
    output wash_req,
    input  motor_en,
    input  motor_dir,
    input  wash_pump,
    input  st,
    input  sweep_cnt
  );

  modport slave (
    input  speed_req,
    input  wash_req,
    output motor_en,
    output motor_dir,
    output wash_pump,
    output st,
    output sweep_cnt
  );

endinterface

// File: rtl/wiper_tick_counter.sv
// Per-state cycle counter with clear, enable and terminal compare.
// Cleared on every state change by the sequencer.
module wiper_tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/wiper_sweep_sequencer.sv
// Wiper motor sweep sequencer: off/slow/fast sweeps with slow dwell.
// Washer arbitration is built only when WIPER_WASH_EN is defined.
import wiper_pkg::*;

module wiper_sweep_sequencer #(
  parameter int SWEEP_TICKS = 4,
  parameter int SLOW_DIV    = 2,
  parameter int DWELL_TICKS = 6,
  parameter int WASH_SWEEPS = 3
) (
  input  logic             clk_2,
  input  logic             reset,
  wiper_sweep_sequencer_if.slave bus
);

  localparam int SLOW_LEN = SWEEP_TICKS * SLOW_DIV;
  localparam int MAX_LEN  =
    (SLOW_LEN > DWELL_TICKS) ? SLOW_LEN : DWELL_TICKS;
  localparam int CW = $clog2(MAX_LEN + 1);

  wiper_state_t  state_q, state_d;
  speed_t        spd_q, spd_d, req;
  logic [7:0]    sweep_q, sweep_d;
  logic          men_q, men_d;
  logic          mdir_q, mdir_d;
  logic [CW-1:0] term;
  logic          tc;
  logic          back_end;
  logic          wash_now;
  logic          wash_next;

  assign req = eff_speed(bus.speed_req);

  assign term = (state_q == DWELL)
    ? CW'(DWELL_TICKS - 1)
    : CW'(half_len(spd_q, SWEEP_TICKS, SLOW_DIV) - 1);

  assign back_end = (state_q == BACK) && tc;

  wiper_tick_counter #(
    .W (CW)
  ) u_tick (
    .clk   (clk_2),
    .rst_n (reset),
    .clr   (state_d != state_q),
    .en    (state_q != PARK),
    .term  (term),
    .tc    (tc)
  );

`ifdef WIPER_WASH_EN
  localparam int WW = $clog2(WASH_SWEEPS + 1);

  logic          wreq_q;
  logic [WW-1:0] wl_q, wl_d;

  // A retrigger reloads even on the cycle a sweep ends.
  always_comb begin
    wl_d = wl_q;
    if (bus.wash_req && !wreq_q) begin
      wl_d = WW'(WASH_SWEEPS);
    end else if (back_end && (wl_q != '0)) begin
      wl_d = wl_q - WW'(1);
    end
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      wreq_q <= 1'b0;
      wl_q   <= '0;
    end else begin
      wreq_q <= bus.wash_req;
      wl_q   <= wl_d;
    end
  end

  assign wash_now  = (wl_q != '0);
  assign wash_next = (wl_d != '0);
`else
  assign wash_now  = 1'b0;
  assign wash_next = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    spd_d   = spd_q;
    sweep_d = sweep_q;
    unique case (state_q)
      PARK: begin
        if (wash_now || (req != SPD_OFF)) begin
          state_d = OUT;
          spd_d   = wash_now ? SPD_FAST : req;
        end
      end
      OUT: begin
        if (tc) state_d = BACK;
      end
      BACK: begin
        if (tc) begin
          sweep_d = sweep_q + 8'd1;
          if (wash_next || (req == SPD_FAST)) begin
            state_d = OUT;
            spd_d   = SPD_FAST;
          end else if (req == SPD_SLOW) begin
            state_d = DWELL;
            spd_d   = SPD_SLOW;
          end else begin
            state_d = PARK;
            spd_d   = SPD_OFF;
          end
        end
      end
      DWELL: begin
        if ((req == SPD_FAST) || wash_now) begin
          state_d = OUT;
          spd_d   = SPD_FAST;
        end else if (req == SPD_OFF) begin
          state_d = PARK;
          spd_d   = SPD_OFF;
        end else if (tc) begin
          state_d = OUT;
          spd_d   = SPD_SLOW;
        end
      end
      default: state_d = PARK;
    endcase
    men_d  = (state_d == OUT) || (state_d == BACK);
    mdir_d = (state_d == OUT);
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state_q <= PARK;
      spd_q   <= SPD_OFF;
      sweep_q <= 8'd0;
      men_q   <= 1'b0;
      mdir_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      spd_q   <= spd_d;
      sweep_q <= sweep_d;
      men_q   <= men_d;
      mdir_q  <= mdir_d;
    end
  end

  assign bus.motor_en  = men_q;
  assign bus.motor_dir = mdir_q;
  assign bus.wash_pump = wash_now;
  assign bus.st        = state_q;
  assign bus.sweep_cnt = sweep_q;

endmodule

// File: tb/tb_wiper_sweep_sequencer.sv
// Scoreboard bench for wiper_sweep_sequencer at default parameters.
// Wash scenarios adapt to whether WIPER_WASH_EN is defined.
module tb_wiper_sweep_sequencer;

  typedef struct {
    int          cyc;
    logic [12:0] v;
    int          tag;
  } exp_t;

  logic clk_2;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  wiper_sweep_sequencer_if bus();

  wiper_sweep_sequencer dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;
  always @(posedge clk_2) cyc <= cyc + 1;

  task automatic put(int c, int st, int dir, int pump, int cnt, int tag);
    exp_t e;
    logic en;
    en    = (st == 1) || (st == 2);
    e.cyc = c;
    e.v   = {2'(st), en, 1'(dir), 1'(pump), 8'(cnt)};
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic nxt(int st, int dir, int pump, int cnt, int tag);
    put(cyc + 1, st, dir, pump, cnt, tag);
    @(negedge clk_2);
  endtask

  function automatic int fst(int k);
    return ((k % 8) < 4) ? 1 : 2;
  endfunction

  function automatic int fdir(int k);
    return ((k % 8) < 4) ? 1 : 0;
  endfunction

  function automatic int sst(int k);
    int p;
    p = k % 22;
    return (p < 8) ? 1 : ((p < 16) ? 2 : 3);
  endfunction

  initial begin : monitor
    exp_t        e;
    logic [12:0] got;
    forever begin
      @(negedge clk_2);
      #1;
      got = {bus.st, bus.motor_en, bus.motor_dir,
             bus.wash_pump, bus.sweep_cnt};
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        checks++;
        if (e.cyc < cyc) begin
          failures++;
          $display("FAIL missed tag=%0d cyc=%0d required=%h",
                   e.tag, e.cyc, e.v);
        end else if (got !== e.v) begin
          failures++;
          $display("FAIL out tag=%0d cyc=%0d actual=%h required=%h",
                   e.tag, cyc, got, e.v);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset         = 1'b0;
    bus.speed_req = 2'd0;
    bus.wash_req  = 1'b0;
    @(negedge clk_2);
    put(cyc, 0, 0, 0, 0, 1);
    @(negedge clk_2);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) nxt(0, 0, 0, 0, 1);

    bus.speed_req = 2'd2;
    for (int k = 0; k < 24; k++) nxt(fst(k), fdir(k), 0, k / 8, 2);
    bus.speed_req = 2'd0;
    nxt(0, 0, 0, 3, 2);

    bus.speed_req = 2'd1;
    for (int k = 0; k < 40; k++)
      nxt(sst(k), (k % 22) < 8 ? 1 : 0, 0, 3 + (k + 6) / 22, 3);
    bus.speed_req = 2'd0;
    nxt(0, 0, 0, 5, 3);
    nxt(0, 0, 0, 5, 3);

    bus.speed_req = 2'd2;
    nxt(1, 1, 0, 5, 4);
    bus.speed_req = 2'd0;
    for (int k = 1; k < 8; k++) nxt(fst(k), fdir(k), 0, 5, 4);
    nxt(0, 0, 0, 6, 4);
    nxt(0, 0, 0, 6, 4);

`ifdef WIPER_WASH_EN
    bus.wash_req = 1'b1;
    nxt(0, 0, 1, 6, 5);
    bus.wash_req = 1'b0;
    for (int k = 1; k < 25; k++)
      nxt(fst(k - 1), fdir(k - 1), 1, 6 + (k - 1) / 8, 5);
    nxt(0, 0, 0, 9, 5);

    bus.wash_req = 1'b1;
    nxt(0, 0, 1, 9, 6);
    for (int k = 1; k < 33; k++) begin
      bus.wash_req = (k == 12);
      nxt(fst(k - 1), fdir(k - 1), 1, 9 + (k - 1) / 8, 6);
    end
    bus.wash_req = 1'b0;
    nxt(0, 0, 0, 13, 6);
`else
    bus.wash_req = 1'b1;
    nxt(0, 0, 0, 6, 5);
    bus.wash_req = 1'b0;
    for (int k = 0; k < 9; k++) nxt(0, 0, 0, 6, 5);
`endif

    @(posedge clk_2);
    #2;
    reset = 1'b0;
    put(cyc, 0, 0, 0, 0, 7);
    @(negedge clk_2);
    reset = 1'b1;
    bus.speed_req = 2'd2;
    for (int k = 0; k < 46; k++) nxt(fst(k), fdir(k), 0, k / 8, 8);
    @(posedge clk_2);
    #2;
    reset = 1'b0;
    put(cyc, 0, 0, 0, 0, 9);
    @(negedge clk_2);
    nxt(0, 0, 0, 0, 9);
    nxt(0, 0, 0, 0, 9);
    reset = 1'b1;
    bus.speed_req = 2'd3;
    for (int k = 0; k < 10; k++) nxt(0, 0, 0, 0, 10);

    @(negedge clk_2);
    @(negedge clk_2);
    while (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL unchecked tag=%0d cyc=%0d required=%h",
               q[0].tag, q[0].cyc, q[0].v);
      void'(q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
